shift_add_mul_feed: RTL and testbench

//  Sequential shift-add multiplier that forms the wide dividend for divider_8191.
//  - Takes a 32-bit operand a and a K-bit operand b; produces x = a*b, K+32 bits.
//  - x connects directly to divider_8191.x, so that stage sees a registered, stable operand.
//  - Handshake: valid/ready on both the input and output sides.

---
 rtl/shift_add_mul_feed_pkg.sv | 11 +
 rtl/shift_add_mul_feed_if.sv | 13 +
 rtl/shift_add_mul_feed_pp_gen.sv | 10 +
 rtl/shift_add_mul_feed.sv | 89 ++++++++
 tb/tb_shift_add_mul_feed.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/shift_add_mul_feed_pkg.sv
// Shared types and helpers for the shift-add multiplier feeding divider_8191.
package shift_add_mul_feed_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mul_state_t;

    // Number of BUSY cycles needed to retire all of b.
    function automatic int steps(input int k, input int bpc);
        return k / bpc;
    endfunction

endpackage

// File: rtl/shift_add_mul_feed_if.sv
// Operand/product handshake bundle between the requester and the multiplier.
interface shift_add_mul_feed_if #(parameter int K = 32);
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   a;
    logic [K-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [K+31:0] x;

    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, x);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, x);
endinterface

// File: rtl/shift_add_mul_feed_pp_gen.sv
// Combinational 32 x BPC partial product of the multiplicand and the low bits of b.
module shift_add_mul_feed_pp_gen #(
    parameter int BPC = 1
) (
    input  logic [31:0]     a,
    input  logic [BPC-1:0]  b,
    output logic [31+BPC:0] p
);
    assign p = (32+BPC)'(a) * (32+BPC)'(b);
endmodule

// File: rtl/shift_add_mul_feed.sv
// Sequential shift-add multiplier: x = a*b over K/BPC cycles, valid/ready on both sides.
module shift_add_mul_feed
    import shift_add_mul_feed_pkg::*;
#(
    parameter int K   = 32,
    parameter int BPC = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    shift_add_mul_feed_if.slave  bus
);
    localparam int STEPS = steps(K, BPC);
    localparam int CW    = $clog2(STEPS) + 1;
    localparam int XW    = K + 32;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BUSY = BUSY;
    localparam logic [1:0] S_DONE = DONE;

    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8) || (K % BPC) != 0) begin : g_bad_cfg
        $error("shift_add_mul_feed: BPC must be 1, 2, 4 or 8 and divide K");
    end

    logic [1:0]     state;
    logic [31:0]    a_r;
    logic [K-1:0]   b_sh;
    logic [CW-1:0]  cnt;
    logic [XW-1:0]  acc;
    logic [XW-1:0]  x_r;
    logic [31+BPC:0] pp;
    logic [31:0]    shamt;
    logic [XW-1:0]  acc_next;
    logic           accept;
    logic           last_step;

    shift_add_mul_feed_pp_gen #(.BPC(BPC)) u_pp_gen (
        .a (a_r),
        .b (b_sh[BPC-1:0]),
        .p (pp)
    );

    assign shamt     = 32'(cnt) * 32'(BPC);
    assign acc_next  = acc + (XW'(pp) << shamt);
    assign last_step = (cnt == CW'(STEPS - 1));

    // DONE accepts only when the current product leaves in the same cycle.
    assign bus.in_ready  = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
    assign bus.out_valid = (state == S_DONE);
    assign bus.x         = x_r;
    assign accept        = bus.in_valid && bus.in_ready;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values,
    // so acc, b_sh and cnt advance together regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            a_r   <= '0;
            b_sh  <= '0;
            cnt   <= '0;
            acc   <= '0;
            x_r   <= '0;
        end else begin
            case (state)
                S_BUSY: begin
                    acc  <= acc_next;
                    b_sh <= b_sh >> BPC;
                    cnt  <= cnt + CW'(1);
                    if (last_step) begin
                        x_r   <= acc_next;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Capture overrides the IDLE/DONE transitions above for back-to-back work.
            if (accept) begin
                a_r   <= bus.a;
                b_sh  <= bus.b;
                acc   <= '0;
                cnt   <= '0;
                state <= S_BUSY;
            end
        end
    end
endmodule

// File: tb/tb_shift_add_mul_feed.sv
// Scoreboard bench for shift_add_mul_feed at BPC=1 and BPC=4 (K=32).
module tb_shift_add_mul_feed;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [63:0] exp_q1[$];
    logic [63:0] exp_q4[$];

    shift_add_mul_feed_if #(.K(32)) bus1 ();
    shift_add_mul_feed_if #(.K(32)) bus4 ();

    shift_add_mul_feed #(.K(32), .BPC(1)) u_dut1 (.clk(clk), .rstn(rstn), .bus(bus1));
    shift_add_mul_feed #(.K(32), .BPC(4)) u_dut4 (.clk(clk), .rstn(rstn), .bus(bus4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 1) ? bus1.in_ready : bus4.in_ready;
    endfunction

    function automatic logic ovalid(input int w);
        return (w == 1) ? bus1.out_valid : bus4.out_valid;
    endfunction

    task automatic set_in(input int w, input logic v, input logic [31:0] a, input logic [31:0] b);
        if (w == 1) begin
            bus1.in_valid = v; bus1.a = a; bus1.b = b;
        end else begin
            bus4.in_valid = v; bus4.a = a; bus4.b = b;
        end
    endtask

    // Scoreboard: a product is consumed on any negedge where valid and ready are both high.
    always @(negedge clk) begin
        if (bus1.out_valid && bus1.out_ready) begin
            if (exp_q1.size() == 0) check("x1_unexpected", bus1.x, 64'hDEAD);
            else check("x1", bus1.x, exp_q1.pop_front());
        end
        if (bus4.out_valid && bus4.out_ready) begin
            if (exp_q4.size() == 0) check("x4_unexpected", bus4.x, 64'hDEAD);
            else check("x4", bus4.x, exp_q4.pop_front());
        end
    end

    // Presents a/b (called just after a posedge), returns the cycle count after the accept edge.
    task automatic accept(input int w, input logic [31:0] a, input logic [31:0] b,
                          input bit push, output int acc_cyc);
        int n = 0;
        set_in(w, 1'b1, a, b);
        do begin
            @(negedge clk);
            n++;
        end while (!rdy(w) && n < 200);
        if (!rdy(w)) check("accept_timeout", 64'(n), 64'd0);
        else if (push) begin
            if (w == 1) exp_q1.push_back(64'(a) * 64'(b));
            else        exp_q4.push_back(64'(a) * 64'(b));
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        set_in(w, 1'b0, a, b);
    endtask

    task automatic wait_valid(input int w, input int acc_cyc, input int exp_lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ovalid(w) && n < 100);
        if (!ovalid(w)) check("valid_timeout", 64'(n), 64'd0);
        else check("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c1, c2;
        logic [63:0] held;
        set_in(1, 1'b0, '0, '0);
        set_in(4, 1'b0, '0, '0);
        bus1.out_ready = 1'b1;
        bus4.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(bus1.out_valid), 64'd0);
        check("rst_x", bus1.x, 64'd0);
        check("rst_in_ready", 64'(bus1.in_ready), 64'd1);
        check("rst_x4", bus4.x, 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        next_cycle();

        // Divider-feed reference vector
        accept(1, 32'd8191, 32'd41943, 1'b1, c1);
        wait_valid(1, c1, 32);
        check("t1_quot", bus1.x / 64'd8191, 64'd41943);
        next_cycle();

        // Maximum operands, both configurations
        accept(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, c1);
        wait_valid(1, c1, 32);
        check("t2_max", bus1.x, 64'hFFFF_FFFE_0000_0001);
        next_cycle();
        accept(4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, c1);
        wait_valid(4, c1, 8);
        next_cycle();
        accept(4, 32'd123456789, 32'd987654321, 1'b1, c1);
        wait_valid(4, c1, 8);
        next_cycle();

        // Zero and unit operands keep full latency
        accept(1, 32'd0, 32'd12345, 1'b1, c1);
        wait_valid(1, c1, 32);
        next_cycle();
        accept(1, 32'd1, 32'd1, 1'b1, c1);
        wait_valid(1, c1, 32);
        next_cycle();

        // Back-to-back with out_ready high: second accept lands on the DONE cycle
        accept(1, 32'd3, 32'd5, 1'b1, c1);
        accept(1, 32'd7, 32'd11, 1'b1, c2);
        check("b2b_spacing", 64'(c2 - c1), 64'd33);
        wait_valid(1, c2, 32);
        next_cycle();

        // Backpressure in DONE: x held, in_ready low, in_valid pulses ignored
        bus1.out_ready = 1'b0;
        accept(1, 32'd8191, 32'd41943, 1'b1, c1);
        wait_valid(1, c1, 32);
        held = bus1.x;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            set_in(1, (i % 2) == 0, 32'd99, 32'd77);
            @(negedge clk);
            check("bp_valid", 64'(bus1.out_valid), 64'd1);
            check("bp_x", bus1.x, 64'd343555113);
            check("bp_in_ready", 64'(bus1.in_ready), 64'd0);
        end
        check("bp_x_stable", bus1.x, held);
        next_cycle();
        set_in(1, 1'b0, '0, '0);
        bus1.out_ready = 1'b1;
        next_cycle();
        repeat (40) @(negedge clk);
        check("bp_no_ghost", 64'(bus1.out_valid), 64'd0);
        next_cycle();

        // Reset mid-BUSY discards the product
        accept(1, 32'd5, 32'd9, 1'b0, c1);
        repeat (10) next_cycle();
        rstn = 1'b0;
        #1;
        check("rst_busy_valid", 64'(bus1.out_valid), 64'd0);
        check("rst_busy_x", bus1.x, 64'd0);
        check("rst_busy_in_ready", 64'(bus1.in_ready), 64'd1);
        next_cycle();
        rstn = 1'b1;
        next_cycle();
        accept(1, 32'd2, 32'd3, 1'b1, c1);
        wait_valid(1, c1, 32);
        next_cycle();
        next_cycle();

        check("q1_drained", 64'(exp_q1.size()), 64'd0);
        check("q4_drained", 64'(exp_q4.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
